// File: rtl/boot_loader_if.sv
// boot_loader_if: bundles the loader's byte-stream input and memory write bus.
//   rx_dv    : one-cycle strobe, rx_byte valid          (UART receiver -> loader)
//   rx_byte  : received byte                            (UART receiver -> loader)
//   mem_sel  : target memory index for we               (loader -> memories)
//   we       : one-cycle write strobe                   (loader -> memories)
//   addr     : word address                             (loader -> memories)
//   wdata    : write data                               (loader -> memories)
// Modport master is the loader side, slave is the receiver/memory side.
interface boot_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int SEL_W  = 1
);
  logic              rx_dv;
  logic [7:0]        rx_byte;
  logic [SEL_W-1:0]  mem_sel;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;

  modport master (input rx_dv, rx_byte, output mem_sel, we, addr, wdata);
  modport slave  (output rx_dv, rx_byte, input mem_sel, we, addr, wdata);
endinterface

// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: program loader. Assembles little-endian DATA_W-bit words
// from a UART byte stream and writes them into one of NUM_MEM memories chosen
// per segment by a header byte. Holds the system in reset while loading.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   prog_i        : programming request level; rising edge starts a session
//   bus           : boot_loader_if.master (rx byte stream in, memory write bus out)
//   prog_rst_no   : system reset, active-low, 0 while loading or after abort
//   done_o        : session completed (sticky)
//   err_o         : session aborted (sticky)
//   word_cnt_o    : words written in the current segment
// Optional: define LOADER_CHECKSUM_EN to require an 8-bit segment checksum
// byte after each terminator word.
//
// state | meaning
// IDLE  | no session since reset
// HDR   | waiting for segment header byte
// LOAD  | collecting bytes of a word
// WRITE | evaluating assembled word (write / terminator / overflow)
// CSUM  | waiting for segment checksum byte (LOADER_CHECKSUM_EN only)
// DONE  | session finished, system released
// ERR   | session aborted, system held in reset
module boot_loader_ctrl #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 12,
  parameter int                NUM_MEM  = 2,
  parameter logic [DATA_W-1:0] END_WORD = 32'h0000_0FFF,
  parameter logic [7:0]        END_HDR  = 8'hFF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                prog_i,
  boot_loader_if.master       bus,
  output logic                prog_rst_no,
  output logic                done_o,
  output logic                err_o,
  output logic [ADDR_W:0]     word_cnt_o
);
  localparam int BPW   = DATA_W / 8;
  localparam int SEL_W = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [8:0]       NUM_MEM9 = 9'(NUM_MEM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_WRITE, S_DONE, S_ERR, S_CSUM} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_WRITE, S_DONE, S_ERR} state_t;
`endif

  state_t            state_q, state_d;
  logic              prog_q;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              rst_n_q, rst_n_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              start, prog_fall, in_session, cap;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;

  function automatic logic [7:0] lane_sum(input logic [DATA_W-1:0] w);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < BPW; i++) s = s + w[i*8 +: 8];
    return s;
  endfunction
`endif

  assign start     = prog_i & ~prog_q;
  assign prog_fall = ~prog_i & prog_q;

  always_comb begin
    in_session = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_WRITE);
`ifdef LOADER_CHECKSUM_EN
    if (state_q == S_CSUM) in_session = 1'b1;
`endif
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    word_cnt_d = word_cnt_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    rst_n_d    = rst_n_q;
    done_d     = done_q;
    err_d      = err_q;
    cap        = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    // A byte arriving together with start is dropped: start wins outright.
    if (start) begin
      state_d    = S_HDR;
      done_d     = 1'b0;
      err_d      = 1'b0;
      rst_n_d    = 1'b0;
      byte_idx_d = '0;
    end else if (prog_fall && in_session) begin
      state_d = S_ERR;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        S_HDR: if (bus.rx_dv) begin
          if (bus.rx_byte == END_HDR) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            rst_n_d = 1'b1;
          end else if ({1'b0, bus.rx_byte} < NUM_MEM9) begin
            state_d    = S_LOAD;
            sel_d      = bus.rx_byte[SEL_W-1:0];
            addr_d     = '0;
            word_cnt_d = '0;
            byte_idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
            sum_d      = '0;
`endif
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        S_LOAD: cap = bus.rx_dv;
        S_WRITE: begin
          if (asm_q == END_WORD) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_HDR;
`endif
          end else if (word_cnt_q[ADDR_W]) begin
            // every address already used; addresses never wrap
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            we_d       = 1'b1;
            addr_d     = word_cnt_q[ADDR_W-1:0];
            wdata_d    = asm_q;
            word_cnt_d = word_cnt_q + 1'b1;
            state_d    = S_LOAD;
            // a byte arriving now belongs to the next word
            cap        = bus.rx_dv;
`ifdef LOADER_CHECKSUM_EN
            sum_d      = sum_q + lane_sum(asm_q);
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: if (bus.rx_dv) begin
          if (bus.rx_byte == sum_q) begin
            state_d = S_HDR;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
    if (cap) begin
      asm_d[byte_idx_q*8 +: 8] = bus.rx_byte;
      if (byte_idx_q == LAST_IDX) begin
        byte_idx_d = '0;
        state_d    = S_WRITE;
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      prog_q     <= 1'b0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      word_cnt_q <= '0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rst_n_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      prog_q     <= prog_i;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      word_cnt_q <= word_cnt_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rst_n_q    <= rst_n_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign bus.mem_sel  = sel_q;
  assign bus.we       = we_q;
  assign bus.addr     = addr_q;
  assign bus.wdata    = wdata_q;
  assign prog_rst_no  = rst_n_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign word_cnt_o   = word_cnt_q;
endmodule

// File: doc/boot_loader_ctrl.md
Name: boot_loader_ctrl

Overview:
Parametrised program loader for the SoC. It is the successor to the single-target ICCM controller. It takes a byte stream from the programming UART receiver and assembles DATA_W-bit little-endian words. It writes the words into one of NUM_MEM target memories (ICCM, DCCM, ...) chosen per segment by a header byte, and holds the system in reset until the session completes.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8 (BPW = DATA_W/8 bytes per word).
ADDR_W, 12, word-address width per target memory.
NUM_MEM, 2, number of selectable target memories (1..16); SEL_W = max(1, $clog2(NUM_MEM)).
END_WORD, 32'h0000_0FFF, segment terminator word (width DATA_W; never written to memory).
END_HDR, 8'hFF, header byte that ends the whole session.

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset
prog_i  in  1  programming-mode request, level; a session starts on its rising edge
rx_dv_i  in  1  one-cycle strobe, rx_byte_i valid
rx_byte_i  in  8  received byte
mem_sel_o  out  SEL_W  target memory index for we_o
we_o  out  1  one-cycle write strobe
addr_o  out  ADDR_W  word address
wdata_o  out  DATA_W  write data
prog_rst_no  out  1  system reset, active-low; 0 while loading
done_o  out  1  session completed successfully (sticky)
err_o  out  1  session aborted (sticky)
word_cnt_o  out  ADDR_W+1  words written in the current segment

Behaviour:
- Reset is synchronous and active-high (rst_i) on clk_i. The block has one clock domain only.
- Reset values: we_o=0, addr_o=0, wdata_o=0, mem_sel_o=0, prog_rst_no=1, done_o=0, err_o=0, word_cnt_o=0, state=IDLE, prog_i edge register=0.
- prog_i edge: registered prog_q; start = prog_i & ~prog_q. Start from any state enters HDR. On entry: done_o=0, err_o=0, prog_rst_no=0, byte index=0. An rx_dv_i in the same cycle as start is ignored.
- IDLE: rx_dv_i ignored.
- HDR, on rx_dv_i:
  - byte==END_HDR -> DONE.
  - byte<NUM_MEM -> mem_sel_o=byte[SEL_W-1:0], addr=0, word_cnt=0, -> LOAD.
  - any other byte -> ERR.
- LOAD, on rx_dv_i: byte shifts into lane [byte_idx*8 +: 8] of the assembly register; byte_idx increments. On the byte with byte_idx==BPW-1, byte_idx returns to 0 and the assembled word is evaluated next cycle in WRITE.
- WRITE (one cycle):
  - word==END_WORD -> no write, -> HDR (or CSUM when LOADER_CHECKSUM_EN is defined).
  - addr overflow (word_cnt == 2^ADDR_W) -> ERR, no write.
  - otherwise: we_o=1 for exactly one cycle with addr_o/wdata_o/mem_sel_o valid that cycle; then addr increments, word_cnt increments, -> LOAD.
- Latency: we_o asserts 2 cycles after the rx_dv_i of the last byte of a word.
- rx_dv_i during WRITE: the byte is captured as byte 0 of the next word and is not dropped. The WRITE cycle is never delayed.
- addr_o wraps never: a write at addr 2^ADDR_W-1 is allowed; the next data word -> ERR.
- DONE: done_o=1, prog_rst_no=1; stays until the next start or reset.
- ERR: err_o=1, prog_rst_no held 0 (the system stays in reset); exits only on a new start or reset.
- prog_i falling while in HDR/LOAD/WRITE/CSUM -> ERR. prog_i falling in DONE/IDLE/ERR has no effect.
- A partial word (byte_idx != 0) is discarded on any exit from LOAD.
- rst_i mid-session: all state is cleared and prog_rst_no returns to 1 in the next cycle. Words already written stay in memory.

Optional Feature:
LOADER_CHECKSUM_EN:
- Defined: each segment carries an 8-bit running sum (mod 256) of every byte received in LOAD, terminator bytes excluded. The sum clears on each header. After the terminator the FSM enters CSUM and waits for one rx_dv_i byte.
  - Byte equals the sum -> HDR.
  - Byte differs -> ERR.
- Not defined: no CSUM state and no sum register; the terminator goes directly to HDR.

Test Plan:
- Nominal ICCM load (DATA_W=32, NUM_MEM=2): start, bytes 00, 13 00 00 00, 93 00 10 00, FF 0F 00 00, FF -> two writes: sel=0 addr0=0x00000013, addr1=0x00100093; done_o=1; prog_rst_no 0 then 1 after the FF header.
- Multi-target: segment 00 with 1 word, segment 01 with words AA BB CC DD, terminator, FF -> second write has mem_sel_o=1, addr_o=0, wdata_o=0xDDCCBBAA.
- Bad header 0x05 -> err_o=1, prog_rst_no=0, no we_o. A new prog_i rising edge clears err_o.
- Overflow with ADDR_W=2: 5 data words -> 4 writes at addr 0..3, then err_o=1.
- prog_i dropped after 2 bytes of a word -> ERR, no we_o. Also: rx_dv_i coincident with the start cycle is ignored, so the next byte is the header.
- With LOADER_CHECKSUM_EN: word 01 02 03 04, terminator, checksum 0x0A -> HDR. Checksum 0x0B -> err_o=1.
